debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Front-end conditioning stage placed directly upstream of the edge detector.
- Takes a raw, asynchronous, bouncy single-bit input (push-button or switch) and synchronises it into the clk domain.
- Filters bounce with a stability counter and FSM.
- Outputs a clean level (db) that feeds the edge detector's in port, plus its own registered rise/fall ticks for consumers that need no separate edge stage.

Parameters:
- STABLE_CYCLES, 1000: consecutive synchronised cycles the input must hold a new value before db changes; legal range >= 1.
- SYNC_STAGES, 2: flip-flop depth of the input synchroniser; legal range >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising clk.
- in  input  1  raw asynchronous input, may bounce.
- db  output  1  debounced level, registered.
- tick_rise  output  1  one-cycle pulse, coincident with the cycle db first reads 1.
- tick_fall  output  1  one-cycle pulse, coincident with the cycle db first reads 0.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is synchronous, active-high; no asynchronous reset anywhere.
- Reset state:
  - Synchroniser flops = 0, FSM = ZERO, stability counter = 0.
  - db = 0, tick_rise = 0, tick_fall = 0.
- Synchroniser: SYNC_STAGES-deep shift chain on in; s = last stage. The FSM sees only s.
- Counter:
  - Width $clog2(STABLE_CYCLES+1).
  - Cleared on entry to WAIT1/WAIT0; increments by 1 each cycle in a WAIT state while s holds the candidate value.
  - Never wraps.
- FSM states and transitions:
  - ZERO (db=0): s==1 -> WAIT1, cnt<=0; otherwise stay.
  - WAIT1 (db=0):
    - s==0 -> ZERO (glitch rejected, no tick).
    - s==1 and cnt==STABLE_CYCLES-1 -> ONE, db<=1, tick_rise<=1.
    - Else cnt++.
  - ONE (db=1): s==0 -> WAIT0, cnt<=0; otherwise stay.
  - WAIT0 (db=1):
    - s==1 -> ONE (no tick).
    - s==0 and cnt==STABLE_CYCLES-1 -> ZERO, db<=0, tick_fall<=1.
    - Else cnt++.
- Latency: with in stable, db changes on the (SYNC_STAGES+STABLE_CYCLES+1)-th rising edge counting the first edge that samples the new value of in. Same latency for both directions.
- Ticks: registered; high exactly one cycle; never both high; never high in the same cycle as rst.
- Boundary conditions:
  - Any reversal of s inside a WAIT state returns to the originating stable state. The counter restarts from 0 on the next WAIT entry; no partial credit.
  - STABLE_CYCLES==1: WAIT state lasts exactly one cycle when s holds.
  - rst asserted mid-WAIT or in ONE: next cycle is the full reset state; db drops to 0 with no tick_fall.
  - in==1 while rst is held: after release, the normal path ZERO -> WAIT1 -> ONE runs with full latency, and tick_rise fires.
- db is glitch-free by construction, safe to feed the edge detector directly.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- When defined:
  - Adds output port glitch_cnt, 8 bits.
  - Saturating counter, reset to 0 by rst.
  - Increments by 1 on every WAIT1->ZERO or WAIT0->ONE abort; holds at 255.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
(All tests use STABLE_CYCLES=4, SYNC_STAGES=2, 10 ns clk.)
- Reset: rst=1 for 2 cycles with in=1 -> db=0, ticks=0 throughout. After release, db=1 on the 7th edge after the first edge sampling in=1, with tick_rise high for exactly that one cycle.
- Clean press/release:
  - in 0->1, held 20 cycles -> db rises 7 edges later, single tick_rise.
  - in 1->0 -> db falls 7 edges later, single tick_fall, tick_rise stays 0.
- Bounce: in toggles 1,0,1,0 each cycle for 6 cycles, then holds 1 -> db stays 0 during bounce and rises 7 edges after the final 0->1; exactly one tick_rise. With macro on, glitch_cnt equals the number of WAIT1 aborts.
- Short pulse: in=1 for 3 cycles only -> db never rises, no ticks.
- Reset mid-operation: in held 1, rst pulsed 1 cycle while in WAIT1 (4 edges after in rises) -> counter aborted; db rises 7 edges after rst release, not earlier.
- Saturation (macro on): 300 isolated 1-cycle pulses on in -> glitch_cnt=255, db=0.

Source files
------------

// File: rtl/debounce_sync.sv
// debounce_sync: synchronises a raw, bouncy single-bit input into the clk
// domain and filters bounce with a stability counter and a four-state FSM.
// It produces a clean registered level plus one-cycle rise/fall ticks.
//
// Parameters:
//   STABLE_CYCLES  consecutive synchronised cycles a new value must hold (>= 1)
//   SYNC_STAGES    synchroniser flop depth (>= 2)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in          raw asynchronous input, may bounce
//   db          debounced level (registered)
//   tick_rise   one-cycle pulse in the first cycle db reads 1 (registered)
//   tick_fall   one-cycle pulse in the first cycle db reads 0 (registered)
//   glitch_cnt  8-bit saturating count of aborted WAIT states
//               (present only when DEBOUNCE_GLITCH_CNT_EN is defined)
//
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       db,
  output logic       tick_rise,
  output logic       tick_fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   db_nxt;
  logic                   tick_rise_nxt;
  logic                   tick_fall_nxt;

  // Input synchroniser; the FSM only ever looks at the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ZERO;
      cnt       <= '0;
      db        <= 1'b0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      db        <= db_nxt;
      tick_rise <= tick_rise_nxt;
      tick_fall <= tick_fall_nxt;
    end
  end

  // Next-state logic. A WAIT state exits on the terminal count before the
  // counter could ever pass CNT_LAST, so the counter cannot wrap.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    db_nxt        = db;
    tick_rise_nxt = 1'b0;
    tick_fall_nxt = 1'b0;
    case (state)
      ZERO: begin
        db_nxt = 1'b0;
        if (s) begin
          state_nxt = WAIT1;
          cnt_nxt   = '0;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_nxt = ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt     = ONE;
          db_nxt        = 1'b1;
          tick_rise_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ONE: begin
        db_nxt = 1'b1;
        if (!s) begin
          state_nxt = WAIT0;
          cnt_nxt   = '0;
        end
      end
      WAIT0: begin
        if (s) begin
          state_nxt = ONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt     = ZERO;
          db_nxt        = 1'b0;
          tick_fall_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ZERO;
        cnt_nxt   = '0;
        db_nxt    = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic abort_c;

  // A reversal of s while waiting sends the FSM back to its stable state.
  assign abort_c = ((state == WAIT1) && !s) || ((state == WAIT0) && s);

  // Saturating abort counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= 8'd0;
    end else if (abort_c && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed testbench for debounce_sync with STABLE_CYCLES=4, SYNC_STAGES=2.
// Expected db latency is 2 + 4 + 1 = 7 edges from the first edge sampling in.
module tb_debounce_sync;

  localparam int unsigned STABLE = 4;
  localparam int unsigned SYNC   = 2;
  localparam int          LAT    = 7;

  logic clk;
  logic rst;
  logic in;
  logic db;
  logic tick_rise;
  logic tick_fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_rise = 0;
  int n_fall = 0;
  int n_both = 0;
  int n_db_high = 0;

  debounce_sync #(
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .db        (db),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick/level tallies sampled on the falling edge.
  always @(negedge clk) begin
    if (tick_rise === 1'b1) n_rise++;
    if (tick_fall === 1'b1) n_fall++;
    if ((tick_rise === 1'b1) && (tick_fall === 1'b1)) n_both++;
    if (db === 1'b1) n_db_high++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tallies();
    n_rise    = 0;
    n_fall    = 0;
    n_db_high = 0;
  endtask

  // Call right after the stimulus change; the next posedge is edge 1.
  task automatic expect_change(input string tag, input logic new_db, input int lat);
    clear_tallies();
    repeat (lat - 1) step();
    chk({tag, "_db_before"}, 32'(db), 32'(!new_db));
    chk({tag, "_early_ticks"}, 32'(n_rise + n_fall), 0);
    step();
    chk({tag, "_db_after"}, 32'(db), 32'(new_db));
    chk({tag, "_tick_on"}, 32'(new_db ? tick_rise : tick_fall), 1);
    step();
    chk({tag, "_tick_off"}, 32'(new_db ? tick_rise : tick_fall), 0);
    chk({tag, "_rise_cnt"}, 32'(n_rise), new_db ? 32'd1 : 32'd0);
    chk({tag, "_fall_cnt"}, 32'(n_fall), new_db ? 32'd0 : 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in  = 1'b1;

    // Reset held with in=1: everything stays low.
    step();
    chk("rst_db_0", 32'(db), 0);
    chk("rst_ticks_0", 32'({tick_rise, tick_fall}), 0);
    step();
    chk("rst_db_1", 32'(db), 0);
    chk("rst_ticks_1", 32'({tick_rise, tick_fall}), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("rst_glitch", 32'(glitch_cnt), 0);
`endif
    rst = 1'b0;
    expect_change("rst_release", 1'b1, LAT);

    // Clean release, then clean press held 20 cycles.
    in = 1'b0;
    expect_change("release", 1'b0, LAT);
    repeat (10) step();
    in = 1'b1;
    expect_change("press", 1'b1, LAT);
    clear_tallies();
    repeat (11) step();
    chk("press_hold_db", 32'(db), 1);
    chk("press_hold_ticks", 32'(n_rise + n_fall), 0);

    // Return to 0, then bounce 1,0,1,0,1,0 and hold 1.
    in = 1'b0;
    repeat (20) step();
    chk("pre_bounce_db", 32'(db), 0);
    clear_tallies();
    for (int i = 0; i < 6; i++) begin
      in = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    chk("bounce_db_high", 32'(n_db_high), 0);
    chk("bounce_ticks", 32'(n_rise + n_fall), 0);
    in = 1'b1;
    expect_change("bounce", 1'b1, LAT);
    clear_tallies();
    repeat (10) step();
    chk("bounce_extra_ticks", 32'(n_rise + n_fall), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("bounce_glitch", 32'(glitch_cnt), 3);
`endif

    // Short 3-cycle pulse never gets through.
    in = 1'b0;
    repeat (20) step();
    clear_tallies();
    in = 1'b1;
    repeat (3) step();
    in = 1'b0;
    repeat (20) step();
    chk("short_db", 32'(db), 0);
    chk("short_db_high", 32'(n_db_high), 0);
    chk("short_ticks", 32'(n_rise + n_fall), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("short_glitch", 32'(glitch_cnt), 4);
`endif

    // Reset pulse in WAIT1 discards progress; full latency after release.
    in = 1'b1;
    repeat (4) step();
    chk("mid_pre_db", 32'(db), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_db", 32'(db), 0);
    chk("mid_rst_ticks", 32'({tick_rise, tick_fall}), 0);
    expect_change("mid_rst", 1'b1, LAT);

    // Reset while in ONE: db drops with no tick_fall.
    repeat (5) step();
    clear_tallies();
    rst = 1'b1;
    in  = 1'b0;
    step();
    chk("one_rst_db", 32'(db), 0);
    chk("one_rst_tick_fall", 32'(tick_fall), 0);
    rst = 1'b0;
    repeat (12) step();
    chk("one_rst_no_ticks", 32'(n_rise + n_fall), 0);
    chk("one_rst_db_low", 32'(db), 0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Isolated 1-cycle pulses each abort WAIT1; counter saturates.
    chk("sat_glitch_start", 32'(glitch_cnt), 0);
    clear_tallies();
    for (int p = 0; p < 300; p++) begin
      in = 1'b1;
      step();
      in = 1'b0;
      repeat (3) step();
      if (p == 9) chk("sat_glitch_10", 32'(glitch_cnt), 10);
    end
    chk("sat_glitch_255", 32'(glitch_cnt), 255);
    chk("sat_db", 32'(db), 0);
    chk("sat_db_high", 32'(n_db_high), 0);
`endif

    chk("ticks_never_both", 32'(n_both), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
